// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared constants, FSM encoding and kernel coefficient/shift tables
package filt_pkg;
    localparam int NUM_TAPS    = 9;
    localparam int COEF_W      = 8;
    localparam int NUM_KERNELS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    typedef logic signed [COEF_W-1:0] coef_t;

    // identity, box, gaussian, sharpen, laplacian, sobel-x, sobel-y, emboss
    localparam coef_t COEF_TABLE [NUM_KERNELS][NUM_TAPS] = '{
        '{ 8'sd0,  8'sd0,  8'sd0,  8'sd0,  8'sd1,  8'sd0,  8'sd0,  8'sd0,  8'sd0},
        '{ 8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1,  8'sd1},
        '{ 8'sd1,  8'sd2,  8'sd1,  8'sd2,  8'sd4,  8'sd2,  8'sd1,  8'sd2,  8'sd1},
        '{ 8'sd0, -8'sd1,  8'sd0, -8'sd1,  8'sd5, -8'sd1,  8'sd0, -8'sd1,  8'sd0},
        '{-8'sd1, -8'sd1, -8'sd1, -8'sd1,  8'sd8, -8'sd1, -8'sd1, -8'sd1, -8'sd1},
        '{-8'sd1,  8'sd0,  8'sd1, -8'sd2,  8'sd0,  8'sd2, -8'sd1,  8'sd0,  8'sd1},
        '{-8'sd1, -8'sd2, -8'sd1,  8'sd0,  8'sd0,  8'sd0,  8'sd1,  8'sd2,  8'sd1},
        '{-8'sd2, -8'sd1,  8'sd0, -8'sd1,  8'sd1,  8'sd1,  8'sd0,  8'sd1,  8'sd2}
    };

    localparam logic [3:0] SHIFT_TABLE [NUM_KERNELS] = '{
        4'd0, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1
    };
endpackage

// File: rtl/filt_coef_rom.sv
// rtl/filt_coef_rom.sv - combinational kernel coefficient and shift lookup
module filt_coef_rom
    import filt_pkg::*;
(
    input  logic [2:0] kernel,
    input  logic [3:0] addr,
    output coef_t      coef,
    output logic [3:0] shift
);
    always_comb begin
        coef  = '0;
        shift = SHIFT_TABLE[kernel];
        if (addr < 4'(NUM_TAPS)) begin
            coef = COEF_TABLE[kernel][addr];
        end
    end
endmodule

// File: rtl/filt_coef_ctrl.sv
// rtl/filt_coef_ctrl.sv - frame-synchronous filter coefficient loader; FILT_COEF_CTRL_WDOG_EN adds a vsync watchdog
module filt_coef_ctrl #(
    parameter int NUM_TAPS    = 9,
    parameter int COEF_W      = 8,
    parameter int WDOG_CYCLES = 2_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               sw,
    input  logic                     rx_vs,
    input  logic                     rx_dv,
    output logic                     coef_we,
    output logic [3:0]               coef_addr,
    output logic signed [COEF_W-1:0] coef_data,
    output logic [3:0]               coef_shift,
    output logic                     coef_commit,
    output logic                     bypass,
    output logic                     busy,
    output logic                     load_err
);
    import filt_pkg::*;

    logic [3:0] sw_meta, sw_sync;   // {sw[7], sw[2:0]}
    logic       vs_q, vs_re;
    state_t     state, state_nxt;
    logic [3:0] tap_cnt;
    logic [3:0] sel;
    logic [3:0] committed;
    logic       committed_ok;
    logic       bypass_q, load_err_q;
    logic [3:0] shift_q;
    logic       load_req, last_tap, wdog_hit;
    logic [2:0] rom_kernel;
    coef_t      rom_coef;
    logic [3:0] rom_shift;
    logic       unused_sw;

    assign unused_sw = ^sw[6:3];

    // In IDLE the ROM looks at the live request so its shift is ready at latch time
    assign rom_kernel = (state == ST_IDLE) ? sw_sync[2:0] : sel[2:0];

    filt_coef_rom u_rom (
        .kernel (rom_kernel),
        .addr   (tap_cnt),
        .coef   (rom_coef),
        .shift  (rom_shift)
    );

    assign load_req = vs_re && (!committed_ok || (sw_sync != committed));
    assign last_tap = (tap_cnt == 4'(NUM_TAPS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (load_req) state_nxt = ST_LOAD;
            ST_LOAD:   if (rx_dv) state_nxt = ST_ABORT;
                       else if (last_tap) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            ST_ABORT:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        coef_we     = (state == ST_LOAD);
        coef_addr   = 4'd0;
        coef_data   = '0;
        coef_commit = (state == ST_COMMIT);
        busy        = (state != ST_IDLE);
        if (state == ST_LOAD) begin
            coef_addr = tap_cnt;
            coef_data = COEF_W'(rom_coef);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta      <= 4'd0;
            sw_sync      <= 4'd0;
            vs_q         <= 1'b0;
            vs_re        <= 1'b0;
            tap_cnt      <= 4'd0;
            sel          <= 4'd0;
            committed    <= 4'd0;
            committed_ok <= 1'b0;
            bypass_q     <= 1'b1;
            load_err_q   <= 1'b0;
            shift_q      <= 4'd0;
        end else begin
            sw_meta <= {sw[7], sw[2:0]};
            sw_sync <= sw_meta;
            vs_q    <= rx_vs;
            vs_re   <= rx_vs & ~vs_q;
            tap_cnt <= (state == ST_LOAD && state_nxt == ST_LOAD) ? tap_cnt + 4'd1 : 4'd0;
            if (state == ST_IDLE && load_req) begin
                sel     <= sw_sync;
                shift_q <= rom_shift;
            end
            if (state == ST_LOAD && rx_dv) begin
                load_err_q <= 1'b1;
            end
            // Bypass and committed selection become visible together with the commit pulse
            if (state == ST_LOAD && state_nxt == ST_COMMIT) begin
                bypass_q     <= sel[3];
                committed    <= sel;
                committed_ok <= 1'b1;
            end
            if (wdog_hit) begin
                bypass_q     <= 1'b1;
                committed_ok <= 1'b0;
            end
        end
    end

`ifdef FILT_COEF_CTRL_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt;

    always_ff @(posedge clk) begin
        if (rst)            wdog_cnt <= '0;
        else if (vs_re)     wdog_cnt <= '0;
        else if (!wdog_hit) wdog_cnt <= wdog_cnt + 1'b1;
    end

    assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES));
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
    assign wdog_hit    = 1'b0;
`endif

    assign bypass     = bypass_q;
    assign load_err   = load_err_q;
    assign coef_shift = shift_q;
endmodule

// File: tb/tb_filt_coef_ctrl.sv
// tb/tb_filt_coef_ctrl.sv - randomized self-checking bench for filt_coef_ctrl
module tb_filt_coef_ctrl;
`ifdef FILT_COEF_CTRL_WDOG_EN
    localparam int WDOG = 100;
`else
    localparam int WDOG = 2_000_000;
`endif

    localparam int REF_COEF [8][9] = '{
        '{ 0,  0,  0,  0,  1,  0,  0,  0,  0},
        '{ 1,  1,  1,  1,  1,  1,  1,  1,  1},
        '{ 1,  2,  1,  2,  4,  2,  1,  2,  1},
        '{ 0, -1,  0, -1,  5, -1,  0, -1,  0},
        '{-1, -1, -1, -1,  8, -1, -1, -1, -1},
        '{-1,  0,  1, -2,  0,  2, -1,  0,  1},
        '{-1, -2, -1,  0,  0,  0,  1,  2,  1},
        '{-2, -1,  0, -1,  1,  1,  0,  1,  2}
    };
    localparam int REF_SHIFT [8] = '{0, 3, 4, 0, 0, 0, 0, 1};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        sw = 8'h00;
    logic              rx_vs = 1'b0;
    logic              rx_dv = 1'b0;
    logic              coef_we, coef_commit, bypass, busy, load_err;
    logic [3:0]        coef_addr, coef_shift;
    logic signed [7:0] coef_data;

    int   checks = 0;
    int   errors = 0;
    bit   m_valid = 1'b0;
    logic [3:0] m_sel = 4'd0;
    bit   m_byp = 1'b1;
    bit   m_err = 1'b0;
    logic [7:0] last_sw = 8'h00;

    filt_coef_ctrl #(.NUM_TAPS(9), .COEF_W(8), .WDOG_CYCLES(WDOG)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .rx_vs       (rx_vs),
        .rx_dv       (rx_dv),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_shift  (coef_shift),
        .coef_commit (coef_commit),
        .bypass      (bypass),
        .busy        (busy),
        .load_err    (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: settle sw, raise rx_vs, then watch 14 cycles counted from the vs_re cycle
    task automatic run_frame(input logic [7:0] swv, input int dv_at, input bit toggle);
        logic [3:0] req;
        bit         do_load, abort;
        int         k, last_busy, last_we;
        sw = swv;
        repeat (4) @(negedge clk);
        req       = {swv[7], swv[2:0]};
        k         = int'(swv[2:0]);
        do_load   = !m_valid || (req != m_sel);
        abort     = do_load && (dv_at >= 1);
        last_we   = abort ? dv_at : 9;
        last_busy = abort ? dv_at + 1 : 10;
        rx_vs     = 1'b1;
        for (int idx = 0; idx < 14; idx++) begin
            bit exp_we;
            @(negedge clk);
            exp_we = do_load && (idx >= 1) && (idx <= last_we);
            if (do_load && !abort && idx == 10) m_byp = req[3];
            if (abort && idx == dv_at + 1) m_err = 1'b1;
            check($sformatf("we[%0d] sw=%0h", idx, swv), 32'(coef_we), 32'(exp_we));
            check($sformatf("addr[%0d] sw=%0h", idx, swv), 32'(coef_addr), exp_we ? 32'(idx - 1) : 32'd0);
            check($sformatf("data[%0d] sw=%0h", idx, swv), 32'(coef_data), exp_we ? 32'(REF_COEF[k][idx - 1]) : 32'd0);
            check($sformatf("commit[%0d] sw=%0h", idx, swv), 32'(coef_commit),
                  32'(do_load && !abort && idx == 10));
            check($sformatf("busy[%0d] sw=%0h", idx, swv), 32'(busy),
                  32'(do_load && idx >= 1 && idx <= last_busy));
            check($sformatf("bypass[%0d] sw=%0h", idx, swv), 32'(bypass), 32'(m_byp));
            check($sformatf("load_err[%0d] sw=%0h", idx, swv), 32'(load_err), 32'(m_err));
            if (exp_we) check($sformatf("shift[%0d] sw=%0h", idx, swv), 32'(coef_shift), 32'(REF_SHIFT[k]));
            if (idx == 2) rx_vs = 1'b0;
            rx_dv = (idx == dv_at);
            if (toggle && idx == 3) sw = swv ^ 8'h87;
        end
        if (do_load && !abort) begin
            m_valid = 1'b1;
            m_sel   = req;
        end
        last_sw = swv;
    endtask

    initial begin
        logic [7:0] s;
        int         dv;
        bit         tg;

        repeat (3) @(negedge clk);
        check("rst coef_we", 32'(coef_we), 32'd0);
        check("rst coef_addr", 32'(coef_addr), 32'd0);
        check("rst coef_data", 32'(coef_data), 32'd0);
        check("rst coef_shift", 32'(coef_shift), 32'd0);
        check("rst coef_commit", 32'(coef_commit), 32'd0);
        check("rst bypass", 32'(bypass), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst load_err", 32'(load_err), 32'd0);
        rst = 1'b0;

        run_frame(8'h01, -1, 1'b0);
        run_frame(8'h01, -1, 1'b0);
        run_frame(8'h81, -1, 1'b0);
        run_frame(8'h02, 5, 1'b0);
        run_frame(8'h02, -1, 1'b0);
        run_frame(8'h05, -1, 1'b1);
        run_frame(8'h79, -1, 1'b0);

        for (int f = 0; f < 16; f++) begin
            s  = ($urandom_range(0, 2) == 0) ? last_sw : 8'($urandom);
            dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
            tg = 1'($urandom_range(0, 1));
            run_frame(s, dv, tg);
        end

        // Reset in the middle of a load must not commit
        s  = {~m_sel[3], 4'b0000, m_sel[2:0] ^ 3'd1};
        sw = s;
        repeat (4) @(negedge clk);
        rx_vs = 1'b1;
        repeat (3) @(negedge clk);
        rx_vs = 1'b0;
        @(negedge clk);
        check("midrst we before rst", 32'(coef_we), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("midrst commit[%0d]", i), 32'(coef_commit), 32'd0);
            check($sformatf("midrst we[%0d]", i), 32'(coef_we), 32'd0);
        end
        check("midrst bypass", 32'(bypass), 32'd1);
        check("midrst load_err", 32'(load_err), 32'd0);
        m_valid = 1'b0;
        m_byp   = 1'b1;
        m_err   = 1'b0;
        run_frame(s, -1, 1'b0);

`ifdef FILT_COEF_CTRL_WDOG_EN
        run_frame(8'h03, -1, 1'b0);
        check("wdog bypass before", 32'(bypass), 32'd0);
        repeat (110) @(negedge clk);
        check("wdog bypass forced", 32'(bypass), 32'd1);
        check("wdog busy", 32'(busy), 32'd0);
        m_valid = 1'b0;
        m_byp   = 1'b1;
        run_frame(8'h03, -1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/filt_coef_ctrl.md
FILT_COEF_CTRL -- requirements
Module: filt_coef_ctrl

Interface
REQ-001 Parameter NUM_TAPS, default 9: coefficients per kernel (3x3).
REQ-002 Parameter COEF_W, default 8: signed coefficient width.
REQ-003 Parameter WDOG_CYCLES, default 2_000_000: watchdog limit in clk cycles.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  pixel clock, the recovered HDMI rx clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 sw  input  8  user switches; sw[2:0] is the kernel index, sw[7] is the bypass request, sw[6:3] are ignored.
REQ-008 rx_vs  input  1  vertical sync from the receiver, active-high.
REQ-009 rx_dv  input  1  active-video flag from the receiver.
REQ-010 coef_we  output  1  coefficient shadow-register write strobe.
REQ-011 coef_addr  output  4  tap index 0..NUM_TAPS-1.
REQ-012 coef_data  output  COEF_W  signed coefficient value.
REQ-013 coef_shift  output  4  right-shift normalisation for the kernel being loaded.
REQ-014 coef_commit  output  1  one-cycle pulse; the filter copies shadow registers to active.
REQ-015 bypass  output  1  filter bypass, frame-synchronous.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 load_err  output  1  sticky abort flag, cleared by reset only.

Function
REQ-018 sw SHALL pass through a 2-flop synchroniser before use.
REQ-019 A rising edge on rx_vs (vs_re) SHALL be detected with a one-cycle registered delay.
REQ-020 States SHALL be IDLE, LOAD, COMMIT and ABORT.
REQ-021 IDLE -> LOAD on vs_re when the synchronised {sw[7],sw[2:0]} differs from the committed value; otherwise the block stays in IDLE.
REQ-022 The requested selection SHALL be latched on vs_re; sw changes during LOAD SHALL be ignored.
REQ-023 LOAD SHALL assert coef_we for NUM_TAPS consecutive cycles.
REQ-024 During LOAD, coef_addr SHALL count 0..NUM_TAPS-1 and coef_data SHALL equal the ROM entry [kernel][addr] in the same cycle.
REQ-025 coef_shift SHALL be held constant throughout LOAD.
REQ-026 LOAD -> COMMIT after tap NUM_TAPS-1.
REQ-027 COMMIT SHALL pulse coef_commit for 1 cycle, update bypass and the committed selection in the same cycle, then go to IDLE.
REQ-028 Latency from vs_re to coef_commit SHALL be exactly NUM_TAPS+1 cycles (10 at default).
REQ-029 If rx_dv=1 in any LOAD cycle, the block SHALL enter ABORT with no commit, set load_err, return to IDLE next cycle and retry at the next vs_re.
REQ-030 A vs_re that occurs while not in IDLE SHALL be ignored.
REQ-031 A bypass-only change SHALL still perform the full LOAD sequence so the shadow registers are coherent.
REQ-032 coef_we=0 outside LOAD.
REQ-033 coef_addr and coef_data SHALL be 0 whenever coef_we=0.

Reset
REQ-034 On rst, the block SHALL enter IDLE.
REQ-035 Reset values: coef_we=0, coef_addr=0, coef_data=0, coef_shift=0, coef_commit=0, bypass=1, busy=0, load_err=0.
REQ-036 On rst, the committed selection SHALL be set to an invalid marker so the first vs_re after reset always triggers a LOAD.
REQ-037 rst asserted mid-LOAD SHALL abandon the load with no commit pulse.

Configuration
REQ-038 Macro FILT_COEF_CTRL_WDOG_EN controls the watchdog.
REQ-039 With FILT_COEF_CTRL_WDOG_EN defined, a counter SHALL clear on each vs_re and saturate at WDOG_CYCLES.
REQ-040 When the counter saturates, the block SHALL force bypass=1 immediately and mark the committed selection invalid, so the next vs_re reloads.
REQ-041 Without FILT_COEF_CTRL_WDOG_EN, no counter SHALL exist and bypass SHALL change only in COMMIT.

Structure
REQ-042 Package filt_pkg SHALL hold NUM_TAPS, COEF_W, the state encoding, the 8x9 coefficient table and the per-kernel shift table.
REQ-043 Kernel 0 SHALL be identity (centre tap = 1, shift = 0).
REQ-044 Sub-module filt_coef_rom SHALL be purely combinational: kernel and addr in, coefficient and shift out.

Verification
REQ-045 Reset, then vs_re with sw=8'h01: 9 coef_we cycles with addr 0..8, then coef_commit 10 cycles after vs_re, bypass=0.
REQ-046 A second vs_re with sw unchanged: no coef_we, busy stays 0.
REQ-047 sw=8'h81 at vs_re: full LOAD, then bypass=1 at commit.
REQ-048 rx_dv=1 at LOAD cycle 4: no commit, load_err=1; the next vs_re completes the load and load_err stays 1.
REQ-049 sw toggled during LOAD: the data matches the kernel latched at vs_re.
REQ-050 With WDOG_CYCLES=100 and FILT_COEF_CTRL_WDOG_EN defined, hold rx_vs=0 for 100 cycles: bypass=1, then the next vs_re reloads.
